// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: stack defaults and the stack command encoding.
// The command is derived from the raw push/pop strobes once and used by the stack control.
package cpu_pkg;

    localparam int STK_DW = 8;
    localparam int STK_AW = 3;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_REPL = 2'b11
    } stk_cmd_t;

    // A replace on an empty stack has nothing to overwrite, so it degrades to a plain push.
    function automatic stk_cmd_t decode_cmd(input logic push, input logic pop, input logic is_empty);
        stk_cmd_t cmd;
        cmd = CMD_IDLE;
        if (push && pop) begin
            cmd = is_empty ? CMD_PUSH : CMD_REPL;
        end else if (push) begin
            cmd = CMD_PUSH;
        end else if (pop) begin
            cmd = CMD_POP;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: register array with one synchronous write port and two asynchronous read ports.
// The array is deliberately left without reset; the control logic never exposes stale slots.
module stack_mem #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/stack_engine.sv
// Full-descending hardware stack with registered top-of-stack, occupancy, SP load
// and sticky overflow/underflow flags.
module stack_engine
    import cpu_pkg::*;
#(
    parameter int DW = STK_DW,
    parameter int AW = STK_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] push_data,
    input  logic          sp_load,
    input  logic [AW-1:0] sp_in,
    input  logic          err_clr,
    output logic [DW-1:0] top,
    output logic [AW-1:0] sp,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf
);

    localparam int         DEPTH     = 2 ** AW;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    stk_cmd_t      cmd;
    logic [AW-1:0] sp_p1;
    logic [AW-1:0] sp_p2;
    logic [AW-1:0] load_p1;
    logic [AW:0]   load_count;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [AW-1:0] raddr_a;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;
    logic          ovf_set;
    logic          unf_set;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    assign cmd        = decode_cmd(push, pop, empty);
    assign sp_p1      = sp + AW'(1);
    assign sp_p2      = sp + AW'(2);
    assign load_p1    = sp_in + AW'(1);
    assign load_count = (AW+1)'(DEPTH - 1) - {1'b0, sp_in};

    // Replace overwrites the current top (sp+1); a push fills the free slot at sp.
    assign mem_we    = !sp_load && ((cmd == CMD_PUSH && !full) || cmd == CMD_REPL);
    assign mem_waddr = (cmd == CMD_REPL) ? sp_p1 : sp;
    assign raddr_a   = sp_load ? load_p1 : sp_p1;

    assign ovf_set = !sp_load && (cmd == CMD_PUSH) && full;
    assign unf_set = !sp_load && (cmd == CMD_POP) && empty;

    stack_mem #(
        .DW(DW),
        .AW(AW)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (push_data),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (sp_p2),
        .rdata_b (rdata_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= AW'(DEPTH - 1);
            count <= '0;
            top   <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            ovf <= ovf_set | (ovf & ~err_clr);
            unf <= unf_set | (unf & ~err_clr);
            if (sp_load) begin
                sp    <= sp_in;
                count <= load_count;
                top   <= (load_count != '0) ? rdata_a : '0;
            end else begin
                case (cmd)
                    CMD_PUSH: begin
                        if (!full) begin
                            sp    <= sp - AW'(1);
                            count <= count + (AW+1)'(1);
                            top   <= push_data;
                        end
                    end
                    CMD_POP: begin
                        if (!empty) begin
                            sp    <= sp_p1;
                            count <= count - (AW+1)'(1);
                            top   <= (count >= (AW+1)'(2)) ? rdata_b : '0;
                        end
                    end
                    CMD_REPL: begin
                        top <= push_data;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine: directed scenarios plus randomized traffic
// checked against a queue-based stack model.
module tb_stack_engine;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          push;
    logic          pop;
    logic [DW-1:0] push_data;
    logic          sp_load;
    logic [AW-1:0] sp_in;
    logic          err_clr;
    logic [DW-1:0] top;
    logic [AW-1:0] sp;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          unf;

    int n_cmp  = 0;
    int n_fail = 0;

    stack_engine #(
        .DW(DW),
        .AW(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .sp_load   (sp_load),
        .sp_in     (sp_in),
        .err_clr   (err_clr),
        .top       (top),
        .sp        (sp),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of all outputs: sp, count, top, empty, full, ovf, unf.
    function automatic logic [18:0] obs();
        return {sp, count, top, empty, full, ovf, unf};
    endfunction

    function automatic logic [18:0] exp_st(input int s, input int c, input int t,
                                           input bit e, input bit f, input bit o, input bit u);
        return {3'(s), 4'(c), 8'(t), e, f, o, u};
    endfunction

    task automatic step(input logic pu, input logic po, input logic [7:0] d,
                        input logic ld, input logic [2:0] si, input logic clr);
        push = pu; pop = po; push_data = d; sp_load = ld; sp_in = si; err_clr = clr;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; sp_load = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [18:0] e;
        e = exp_st(7, 0, 0, 1, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL reset_held: got %h required %h", obs(), e);
        end
        rst = 1'b0;
        step(0, 0, 8'h00, 0, 3'd0, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL reset_idle: got %h required %h", obs(), e);
        end
    endtask

    task automatic test_push_pop();
        logic [7:0]  vals [3];
        logic [18:0] e;
        int c;
        vals = '{8'h11, 8'h22, 8'h33};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, vals[i], 0, 3'd0, 0);
            e = exp_st(6 - i, i + 1, vals[i], 0, 0, 0, 0);
            n_cmp++;
            if (obs() !== e) begin
                n_fail++;
                $display("[TB] FAIL push_%0d: got %h required %h", i, obs(), e);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 8'h00, 0, 3'd0, 0);
            c = 2 - i;
            e = exp_st(7 - c, c, (c > 0) ? vals[c-1] : 0, c == 0, 0, 0, 0);
            n_cmp++;
            if (obs() !== e) begin
                n_fail++;
                $display("[TB] FAIL pop_%0d: got %h required %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_overflow();
        logic [18:0] e;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 8'(i), 0, 3'd0, 0);
            e = exp_st((7 - i) & 7, i, i, 0, i == 8, 0, 0);
            n_cmp++;
            if (obs() !== e) begin
                n_fail++;
                $display("[TB] FAIL fill_%0d: got %h required %h", i, obs(), e);
            end
        end
        step(1, 0, 8'hFF, 0, 3'd0, 0);
        e = exp_st(7, 8, 8'h08, 0, 1, 1, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL push_full: got %h required %h", obs(), e);
        end
        step(0, 0, 8'h00, 0, 3'd0, 1);
        e = exp_st(7, 8, 8'h08, 0, 1, 0, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL ovf_clear: got %h required %h", obs(), e);
        end
        step(1, 1, 8'h77, 0, 3'd0, 0);
        e = exp_st(7, 8, 8'h77, 0, 1, 0, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL replace_full: got %h required %h", obs(), e);
        end
        step(0, 1, 8'h00, 0, 3'd0, 0);
        e = exp_st(0, 7, 8'h07, 0, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL pop_wrap: got %h required %h", obs(), e);
        end
    endtask

    task automatic test_underflow();
        logic [18:0] e;
        do_reset();
        step(0, 1, 8'h00, 0, 3'd0, 0);
        e = exp_st(7, 0, 0, 1, 0, 0, 1);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL pop_empty: got %h required %h", obs(), e);
        end
        step(0, 1, 8'h00, 0, 3'd0, 1);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL unf_set_wins: got %h required %h", obs(), e);
        end
        step(0, 0, 8'h00, 0, 3'd0, 1);
        e = exp_st(7, 0, 0, 1, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL unf_clear: got %h required %h", obs(), e);
        end
    endtask

    task automatic test_replace();
        logic [18:0] e;
        do_reset();
        step(1, 0, 8'h10, 0, 3'd0, 0);
        step(1, 0, 8'h20, 0, 3'd0, 0);
        step(1, 1, 8'h99, 0, 3'd0, 0);
        e = exp_st(5, 2, 8'h99, 0, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL replace: got %h required %h", obs(), e);
        end
        step(0, 1, 8'h00, 0, 3'd0, 0);
        e = exp_st(6, 1, 8'h10, 0, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL pop_after_replace: got %h required %h", obs(), e);
        end
        step(0, 1, 8'h00, 0, 3'd0, 0);
        step(1, 1, 8'h5A, 0, 3'd0, 0);
        e = exp_st(6, 1, 8'h5A, 0, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL replace_empty: got %h required %h", obs(), e);
        end
    endtask

    task automatic test_sp_load();
        logic [18:0] e;
        do_reset();
        step(1, 0, 8'hAA, 0, 3'd0, 0);
        step(1, 0, 8'hBB, 0, 3'd0, 0);
        step(1, 0, 8'hCC, 0, 3'd0, 0);
        step(1, 0, 8'hEE, 1, 3'd5, 0);
        e = exp_st(5, 2, 8'hBB, 0, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL load_5: got %h required %h", obs(), e);
        end
        step(0, 1, 8'h00, 0, 3'd0, 0);
        e = exp_st(6, 1, 8'hAA, 0, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL pop_after_load: got %h required %h", obs(), e);
        end
        step(0, 1, 8'h00, 1, 3'd7, 0);
        e = exp_st(7, 0, 0, 1, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL load_7: got %h required %h", obs(), e);
        end
    endtask

    task automatic test_async_reset();
        logic [18:0] e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 8'(8'hC0 + i), 0, 3'd0, 0);
        end
        #2;
        rst = 1'b1;
        #1;
        e = exp_st(7, 0, 0, 1, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %h required %h", obs(), e);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 0, 8'h42, 0, 3'd0, 0);
        e = exp_st(6, 1, 8'h42, 0, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL push_after_reset: got %h required %h", obs(), e);
        end
    endtask

    // Reference: a queue holding the stack bottom-first; SP and flags follow from its size.
    task automatic test_random();
        logic [7:0]  q [$];
        logic [18:0] e;
        bit   m_ovf, m_unf, o_set, u_set;
        int   bias, size, m_sp, m_top, newc;
        logic pu, po, ld, clr;
        logic [7:0] d;
        logic [2:0] si;
        do_reset();
        m_ovf = 0;
        m_unf = 0;
        for (int n = 0; n < 600; n++) begin
            bias = ((n / 100) % 2 == 0) ? 75 : 25;
            size = q.size();
            m_sp = (7 - size) & 7;
            ld   = ($urandom_range(0, 99) < 5);
            pu   = ($urandom_range(0, 99) < bias);
            po   = ($urandom_range(0, 99) < (100 - bias));
            clr  = ($urandom_range(0, 9) == 0);
            d    = 8'($urandom);
            si   = 3'($urandom_range(m_sp, 7));
            o_set = 0;
            u_set = 0;
            if (ld) begin
                newc = 7 - int'(si);
                while (q.size() > newc) void'(q.pop_back());
            end else if (pu && po) begin
                if (size > 0) q[size-1] = d;
                else q.push_back(d);
            end else if (pu) begin
                if (size == 8) o_set = 1;
                else q.push_back(d);
            end else if (po) begin
                if (size == 0) u_set = 1;
                else void'(q.pop_back());
            end
            m_ovf = o_set | (m_ovf & !clr);
            m_unf = u_set | (m_unf & !clr);
            step(pu, po, d, ld, si, clr);
            size  = q.size();
            m_top = (size > 0) ? int'(q[size-1]) : 0;
            e = exp_st((7 - size) & 7, size, m_top, size == 0, size == 8, m_ovf, m_unf);
            n_cmp++;
            if (obs() !== e) begin
                n_fail++;
                $display("[TB] FAIL random_%0d: got %h required %h", n, obs(), e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        push = 1'b0;
        pop = 1'b0;
        push_data = '0;
        sp_load = 1'b0;
        sp_in = '0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace();
        test_sp_load();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_engine.md
# stack_engine

Parametrised hardware stack for the CPU datapath: a full-descending stack pointer plus on-block storage, push/pop/replace commands, occupancy tracking and sticky overflow/underflow flags. It is the successor to the 8-bit SP register. Width and depth are generic, and it adds bounds checking, a registered top-of-stack, and SP load for context switches. It sits between the accumulator bus and the control unit, serving CALL/RET and data push/pop.

## Interface
- `DW`, default 8: data width.
- `AW`, default 3: SP width; depth `DEPTH = 2**AW`.
- `clk` in 1: system clock; all state changes on rising edge.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high (`clk`, `rst`); polarity and synchronicity fixed.
- `push` in 1: write `push_data` onto stack.
- `pop` in 1: remove top entry.
- `push_data` in DW: data to push.
- `sp_load` in 1: load SP from `sp_in`; highest priority.
- `sp_in` in AW: new SP value.
- `err_clr` in 1: clear sticky flags.
- `top` out DW: registered top-of-stack; 0 when empty.
- `sp` out AW: stack pointer (next free slot).
- `count` out AW+1: number of valid entries, 0..DEPTH.
- `empty` out 1: `count == 0`.
- `full` out 1: `count == DEPTH`.
- `ovf` out 1: sticky, push attempted while full.
- `unf` out 1: sticky, pop attempted while empty.

## Operation
- Full-descending: `sp` points to the next free slot; the top entry is at `mem[sp+1]`. All SP arithmetic is modulo DEPTH.
- Reset state: `sp = DEPTH-1`, `count = 0`, `top = 0`, `empty = 1`, `full = 0`, `ovf = unf = 0`. Storage is not reset.
- Command priority per cycle: `sp_load` > push/pop combination > idle.
- **push only, not full:**
  - `mem[sp] <= push_data`
  - `sp <= sp-1`
  - `count+1`
  - `top <= push_data`
- **push only, full:** state unchanged; `ovf <= 1`.
- **pop only, not empty:**
  - `sp <= sp+1`
  - `count-1`
  - `top <= mem[sp+2]` if `count >= 2`, else 0.
- **pop only, empty:** state unchanged; `unf <= 1`.
- **push and pop together (replace):**
  - Not empty: `mem[sp+1] <= push_data`, `top <= push_data`; `sp` and `count` unchanged. No `ovf`, even when full.
  - Empty: acts as a plain push, with no `unf`.
- **sp_load:**
  - `sp <= sp_in`
  - `count <= DEPTH-1-sp_in`
  - `top <= mem[sp_in+1]` if the new count is nonzero, else 0.
  - push/pop in the same cycle are ignored and raise no flags.
  - The full state cannot be reached by load.
- **err_clr:** clears `ovf`/`unf`. If a new error occurs in the same cycle, set wins.
- `empty`/`full` are decoded from the registered `count`.

## Timing
- All outputs are registered. A command sampled at edge N is visible on the outputs after edge N. Single-cycle latency, no stalls, back-to-back commands every cycle.
- No handshake: the block always accepts. Rejected commands only set flags.
- A pop immediately after a push returns the pushed value; a pop-pop sequence has no bubble.
- `rst` asserted mid-operation returns all outputs to reset values immediately, regardless of `clk`. Storage contents are undefined afterwards and never observable, because `count = 0`.
- After `rst` deasserts, commands are honoured from the next rising edge.

## Structure
- Shared package `cpu_pkg` holds:
  - defaults `STK_DW = 8`, `STK_AW = 3`
  - the command-priority encoding, as a 2-bit `stk_cmd_t`: IDLE/PUSH/POP/REPL, decoded internally from push/pop.
- Sub-module `stack_mem`: DW×DEPTH register array with one synchronous write port and two asynchronous read ports (`sp+1`, `sp+2`, or the `sp_in+1` path muxed). No reset on the array.
- The top level holds the SP/count/top/flag registers and the command decode.

## Test plan
- Reset, then 3 pushes of 0x11, 0x22, 0x33. Expect `sp` 7→4, `count = 3`, `top = 0x33`. Then 3 pops: `top` goes 0x22, 0x11, 0, `empty = 1`, `sp = 7`.
- 8 pushes (0x01..0x08). Expect `full = 1`, `sp = 7`, `count = 8`. A 9th push (0xFF) leaves `top = 0x08` and sets `ovf`. `err_clr` then clears `ovf`.
- Pop on empty: `unf = 1`, `sp` stays 7. Pop with `err_clr` in the same cycle: `unf` stays 1 (set wins).
- Push 0x10, 0x20, then push+pop with 0x99. Expect `top = 0x99`, `count = 2`, `sp = 5`. A subsequent pop gives `top = 0x10`. Push+pop on empty with 0x5A gives `count = 1`, `top = 0x5A`, no `unf`.
- Push 0xAA, 0xBB, 0xCC, then `sp_load` `sp_in = 5` together with push. Expect `sp = 5`, `count = 2`, `top = 0xBB`, no write. Then `sp_load` 7: `count = 0`, `top = 0`, `empty = 1`.
- Assert `rst` asynchronously mid-sequence, between edges, with `count = 4`. Expect all outputs at reset values before the next edge. A push after release behaves as the first push.
